// File: rtl/ysyx_23060229_exu.sv
// ysyx_23060229_exu: execute stage of the single-issue RV32 core.
// Takes decoded operands over a valid/ready handshake and computes the ALU or
// branch result. The result lands in a one-entry output register that has its
// own valid/ready handshake.
// Optional feature: define YSYX_23060229_EXU_MUL_EN to add op 16 (MUL). MUL is
// a shift-add multiplier that runs for MUL_CYCLES iterations. Without the macro,
// op 16 is illegal and busy is tied low.
module ysyx_23060229_exu #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_br_taken,
    output logic [XLEN-1:0] out_br_target,
    output logic            out_illegal,
    output logic            busy
);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_SLL  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_SLT  = 5'd8;
    localparam logic [4:0] OP_SLTU = 5'd9;
    localparam logic [4:0] OP_BEQ  = 5'd10;
    localparam logic [4:0] OP_BNE  = 5'd11;
    localparam logic [4:0] OP_BLT  = 5'd12;
    localparam logic [4:0] OP_BGE  = 5'd13;
    localparam logic [4:0] OP_BLTU = 5'd14;
    localparam logic [4:0] OP_BGEU = 5'd15;
`ifdef YSYX_23060229_EXU_MUL_EN
    localparam logic [4:0] OP_MUL  = 5'd16;
`endif

    // The datapath is written for a 32-bit core only.
    if (XLEN != 32 || MUL_CYCLES < 1) begin : g_param_check
        $error("ysyx_23060229_exu: XLEN must be 32 and MUL_CYCLES at least 1");
    end

    logic [XLEN:0]   diff_wide;
    logic [XLEN-1:0] diff;
    logic            ovf;
    logic            lt_s;
    logic            lt_u;
    logic            eq;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] br_target;
    logic            br_taken;
    logic            is_branch;
    logic            is_illegal;
    logic            is_mul;
    logic            accept;
    logic            mul_write;
    logic [XLEN-1:0] mul_result;
    logic [4:0]      mul_rd;

    // One shared subtractor drives SUB, SLT/SLTU and all the branch compares.
    // The signed compare uses the overflow-corrected sign of the difference.
    // The unsigned compare is the borrow out of the widened subtract.
    assign diff_wide = {1'b0, in_src1} - {1'b0, in_src2};
    assign diff      = diff_wide[XLEN-1:0];
    assign ovf       = (in_src1[XLEN-1] != in_src2[XLEN-1]) && (diff[XLEN-1] != in_src1[XLEN-1]);
    assign lt_s      = diff[XLEN-1] ^ ovf;
    assign lt_u      = diff_wide[XLEN];
    assign eq        = (in_src1 == in_src2);
    assign br_target = is_branch ? (in_pc + in_imm) : '0;

    assign in_ready = !busy && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Decode the op into a single-cycle result, branch outcome and illegal flag.
    always_comb begin
        alu_res    = '0;
        br_taken   = 1'b0;
        is_branch  = 1'b0;
        is_illegal = 1'b0;
        is_mul     = 1'b0;
        case (in_op)
            OP_ADD:  alu_res = in_src1 + in_src2;
            OP_SUB:  alu_res = diff;
            OP_AND:  alu_res = in_src1 & in_src2;
            OP_OR:   alu_res = in_src1 | in_src2;
            OP_XOR:  alu_res = in_src1 ^ in_src2;
            OP_SLL:  alu_res = in_src1 << in_src2[4:0];
            OP_SRL:  alu_res = in_src1 >> in_src2[4:0];
            OP_SRA:  alu_res = $signed(in_src1) >>> in_src2[4:0];
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            OP_BEQ:  begin is_branch = 1'b1; br_taken = eq;    end
            OP_BNE:  begin is_branch = 1'b1; br_taken = !eq;   end
            OP_BLT:  begin is_branch = 1'b1; br_taken = lt_s;  end
            OP_BGE:  begin is_branch = 1'b1; br_taken = !lt_s; end
            OP_BLTU: begin is_branch = 1'b1; br_taken = lt_u;  end
            OP_BGEU: begin is_branch = 1'b1; br_taken = !lt_u; end
`ifdef YSYX_23060229_EXU_MUL_EN
            OP_MUL:  is_mul = 1'b1;
`endif
            default: is_illegal = 1'b1;
        endcase
    end

`ifdef YSYX_23060229_EXU_MUL_EN
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} mul_state_t;

    localparam int               CNT_W    = $clog2(MUL_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    mul_state_t       state;
    logic [XLEN-1:0]  mul_acc;
    logic [XLEN-1:0]  mul_mcand;
    logic [XLEN-1:0]  mul_mplr;
    logic [CNT_W-1:0] mul_cnt;
    logic [4:0]       mul_rd_q;

    // A finished product may enter the output register only when that register
    // is empty or is being drained on the same edge.
    assign mul_write  = (state == ST_DONE) && (!out_valid || out_ready);
    assign mul_result = mul_acc;
    assign mul_rd     = mul_rd_q;

    // Shift-add sequencer: consume one multiplier bit per cycle, then wait in DONE for the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            mul_acc   <= '0;
            mul_mcand <= '0;
            mul_mplr  <= '0;
            mul_cnt   <= '0;
            mul_rd_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && is_mul) begin
                        mul_acc   <= '0;
                        mul_mcand <= in_src1;
                        mul_mplr  <= in_src2;
                        mul_cnt   <= '0;
                        mul_rd_q  <= in_rd;
                        busy      <= 1'b1;
                        state     <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (mul_mplr[0]) begin
                        mul_acc <= mul_acc + mul_mcand;
                    end
                    mul_mcand <= mul_mcand << 1;
                    mul_mplr  <= mul_mplr >> 1;
                    mul_cnt   <= mul_cnt + CNT_W'(1);
                    if (mul_cnt == CNT_LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (mul_write) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    assign busy       = 1'b0;
    assign mul_write  = 1'b0;
    assign mul_result = '0;
    assign mul_rd     = '0;
`endif

    // Output register: load on accept or MUL completion, hold while stalled, clear valid once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_rd        <= '0;
            out_br_taken  <= 1'b0;
            out_br_target <= '0;
            out_illegal   <= 1'b0;
        end else if (accept && !is_mul) begin
            out_valid     <= 1'b1;
            out_result    <= alu_res;
            out_rd        <= in_rd;
            out_br_taken  <= br_taken;
            out_br_target <= br_target;
            out_illegal   <= is_illegal;
        end else if (mul_write) begin
            out_valid     <= 1'b1;
            out_result    <= mul_result;
            out_rd        <= mul_rd;
            out_br_taken  <= 1'b0;
            out_br_target <= '0;
            out_illegal   <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/ysyx_23060229_exu.md
Name: ysyx_23060229_exu

Overview:
- Execute stage of the single-issue RV32 core; sits between decode and writeback/LSU.
- Takes decoded operands through a valid/ready handshake and computes the ALU result.
- SLT/SLTU and the branch compares share one compare datapath. The signed path uses the overflow-corrected subtract rule.
- Registers the result into a one-entry output stage with its own valid/ready handshake.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- MUL_CYCLES, 32, iterations of the shift-add multiplier; only used with the optional feature.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode presents an op
- in_ready  out  1  EXU accepts an op this cycle
- in_op  in  5  operation code (see Behaviour)
- in_src1  in  32  rs1 value
- in_src2  in  32  rs2 value or immediate
- in_pc  in  32  PC of the instruction
- in_imm  in  32  branch offset, sign-extended
- in_rd  in  5  destination register index
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  downstream consumes the result
- out_result  out  32  ALU/MUL result
- out_rd  out  5  registered rd
- out_br_taken  out  1  branch resolved taken
- out_br_target  out  32  in_pc + in_imm for branch ops
- out_illegal  out  1  unsupported op code
- busy  out  1  multi-cycle op in progress

Behaviour:
- Reset (rst_n low, asynchronous): all registered outputs go to 0, busy = 0 and the FSM goes to IDLE. Reset mid-multiply discards the op with no output.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA; shift amount is src2[4:0]
  - 8 SLT, 9 SLTU
  - 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU
  - 16 MUL (optional)
  - 17–31 illegal
- Signed less-than: d = src1 - src2 (32-bit wrap); ovf = (src1[31] != src2[31]) && (d[31] != src1[31]); lt = d[31] ^ ovf.
- Unsigned less-than: the borrow out of a 33-bit subtraction {0,src1} - {0,src2}.
- SLT/SLTU produce {31'b0, lt}. Arithmetic wraps modulo 2^32 with no overflow trap.
- Branch ops:
  - out_result = 0, out_br_target = in_pc + in_imm (wraps), out_br_taken = compare outcome.
  - Non-branch ops set out_br_taken = 0 and out_br_target = 0.
- Illegal ops: out_result = 0, out_illegal = 1, latency 1.
- in_ready = !busy && (!out_valid || out_ready). A transfer occurs when in_valid && in_ready.
- Single-cycle ops: the result is registered on the accept edge, so out_valid = 1 from the next cycle (latency 1).
- Output register holds: while out_valid && !out_ready, every out_* stays stable and in_ready = 0.
- Simultaneous drain and accept (out_valid && out_ready && in_valid): the new result replaces the old one in the same edge, sustaining 1 op/cycle.
- out_valid clears when consumed and no new op is accepted.
- in_* are don't-care when in_valid = 0. in_op and the operands are captured only on transfer.

Optional Feature:
- Macro YSYX_23060229_EXU_MUL_EN.
- Defined: op 16 = MUL (low 32 bits of the product; sign-agnostic).
- FSM IDLE -> MUL on accept: latch the operands, busy = 1, in_ready = 0.
- Shift-add, one multiplier bit per cycle, for MUL_CYCLES cycles. Then MUL -> DONE: write out_result/out_rd and assert out_valid; busy = 0.
- The result waits in the output register under the normal hold rule. Total latency is MUL_CYCLES + 1 cycles from accept to out_valid.
- An earlier result still waiting in the output register keeps its hold while MUL iterates; the MUL completion waits until the register is free.
- Undefined: op 16 is illegal (result 0, out_illegal = 1, latency 1), busy is tied to 0, and no FSM is generated.

Test Plan:
- SLT with src1 = 0x80000000, src2 = 0x00000001 -> out_result 1. Swapped operands -> 0. SLTU with 0x80000000, 1 -> 0.
- SLT with src1 = 0x7FFFFFFF, src2 = 0xFFFFFFFF (overflow case) -> 0. ADD with 0xFFFFFFFF + 1 -> 0. SRA of 0x80000000 by 4 -> 0xF8000000.
- BLT with pc = 0x80000000, imm = 0xFFFFFFF8, src1 = -1, src2 = 0 -> br_taken 1, target 0x7FFFFFF8. BGEU with the same operands -> br_taken 1.
- Back-to-back ADDs with out_ready held 0 for 3 cycles: first result stable, in_ready 0, no loss. Then out_ready = 1 streams 1 result/cycle in order.
- With MUL_EN, MUL 0x00010003 * 0x00000005 -> 0x0005000F after 33 cycles, busy high throughout. Without MUL_EN, op 16 -> out_illegal 1, result 0, after 1 cycle.
- rst_n pulsed low mid-MUL (cycle 10) -> out_valid 0, busy 0, in_ready 1 after release, no stale result emitted.
